// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select encodings, the NOP word
// and the HALT opcode used by the fetch stage.
package mips_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JR     = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  OPC_HALT  = 6'b111111;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[31:26] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: synchronous program-load write port,
// asynchronous read port, contents untouched by reset.
module instr_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, next-PC select, instruction memory
// and the IF/ID pipeline register with a HALT freeze.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [1:0]          i_pc_src,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic [PC_WIDTH-1:0] i_jump_target,
  input  logic [PC_WIDTH-1:0] i_jr_target,
  input  logic                i_imem_we,
  input  logic [AW-1:0]       i_imem_waddr,
  input  logic [31:0]         i_imem_wdata,
  output logic [31:0]         o_instr,
  output logic [15:0]         o_imm16,
  output logic [PC_WIDTH-1:0] o_pc_plus4,
  output logic                o_valid,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_halt
);

  // o_valid qualifies the IF/ID contents: when high, o_instr/o_pc_plus4 are a
  // real fetched instruction; when low they are a NOP bubble. There is no
  // back-pressure path other than i_stall/i_enable holding the register.

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] next_pc;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pp4_q, pp4_d;
  logic                valid_q, valid_d;
  logic [31:0]         fetch_word;
  logic                mem_we;
  logic                halt_in_ifid;

  // Program load is only honoured while the pipeline is frozen.
  assign mem_we = i_imem_we && !i_enable;

  instr_mem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (i_imem_waddr),
    .wdata (i_imem_wdata),
    .raddr (pc_q[AW+1:2]),
    .rdata (fetch_word)
  );

  assign pc_plus4     = pc_q + PC_WIDTH'(4);
  assign halt_in_ifid = valid_q && is_halt(instr_q);

  always_comb begin
    next_pc = pc_plus4;
    unique case (i_pc_src)
      PC_SRC_SEQ:    next_pc = pc_plus4;
      PC_SRC_BRANCH: next_pc = i_branch_target;
      PC_SRC_JUMP:   next_pc = i_jump_target;
      PC_SRC_JR:     next_pc = i_jr_target;
      default:       next_pc = pc_plus4;
    endcase
  end

  // A HALT sitting valid in IF/ID freezes fetch on the following enabled
  // edge; only a flush (the HALT was speculative) or reset releases it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    if (i_enable) begin
      if (i_flush) begin
        pc_d    = next_pc;
        instr_d = NOP_INSTR;
        pp4_d   = '0;
        valid_d = 1'b0;
        state_d = FETCH_RUN;
      end else if (state_q == FETCH_RUN) begin
        if (halt_in_ifid) begin
          state_d = FETCH_HALTED;
        end else if (!i_stall) begin
          pc_d    = next_pc;
          instr_d = fetch_word;
          pp4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_RUN;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      pp4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

  assign o_instr    = instr_q;
  assign o_imm16    = instr_q[15:0];
  assign o_pc_plus4 = pp4_q;
  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_halt     = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed program/redirect/halt sequence
// with literal expectations, then randomized traffic against a reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        i_enable;
  logic        i_stall;
  logic        i_flush;
  logic [1:0]  i_pc_src;
  logic [31:0] i_branch_target;
  logic [31:0] i_jump_target;
  logic [31:0] i_jr_target;
  logic        i_imem_we;
  logic [7:0]  i_imem_waddr;
  logic [31:0] i_imem_wdata;
  logic [31:0] o_instr;
  logic [15:0] o_imm16;
  logic [31:0] o_pc_plus4;
  logic        o_valid;
  logic [31:0] o_pc;
  logic        o_halt;

  fetch_stage #(.PC_WIDTH(32), .IMEM_DEPTH(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (i_enable),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_pc_src        (i_pc_src),
    .i_branch_target (i_branch_target),
    .i_jump_target   (i_jump_target),
    .i_jr_target     (i_jr_target),
    .i_imem_we       (i_imem_we),
    .i_imem_waddr    (i_imem_waddr),
    .i_imem_wdata    (i_imem_wdata),
    .o_instr         (o_instr),
    .o_imm16         (o_imm16),
    .o_pc_plus4      (o_pc_plus4),
    .o_valid         (o_valid),
    .o_pc            (o_pc),
    .o_halt          (o_halt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Architectural view: memory array, PC, latched IF/ID word, its PC+4,
  // a valid bit and a halted bit, advanced once per clock edge.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_halted;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    logic        halt_waiting;
    case (i_pc_src)
      2'b00:   tgt = m_pc + 32'd4;
      2'b01:   tgt = i_branch_target;
      2'b10:   tgt = i_jump_target;
      default: tgt = i_jr_target;
    endcase
    halt_waiting = m_valid && (m_instr[31:26] == 6'h3F);
    if (!i_enable) begin
      if (i_imem_we) m_mem[i_imem_waddr] = i_imem_wdata;
    end else if (i_flush) begin
      m_pc = tgt; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      // frozen
    end else if (halt_waiting) begin
      m_halted = 1;
    end else if (!i_stall) begin
      m_instr = m_mem[m_pc[9:2]];
      m_pp4   = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = tgt;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("instr", o_instr, m_instr);
      check("imm16", {16'h0, o_imm16}, {16'h0, m_instr[15:0]});
      check("pc_plus4", o_pc_plus4, m_pp4);
      check("valid", {31'h0, o_valid}, {31'h0, m_valid});
      check("pc", o_pc, m_pc);
      check("halt", {31'h0, o_halt}, {31'h0, m_halted});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic st, input logic fl,
                       input logic [1:0] src, input logic [31:0] tgt,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd);
    i_enable = en; i_stall = st; i_flush = fl; i_pc_src = src;
    i_branch_target = tgt; i_jump_target = tgt; i_jr_target = tgt;
    i_imem_we = we; i_imem_waddr = wa; i_imem_wdata = wd;
    @(posedge clk);
    if (rst_n) model_edge();
    #2;
  endtask

  task automatic step();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, a, d);
  endtask

  task automatic flush_to(input logic [1:0] src, input logic [31:0] tgt, input logic st);
    drive(1'b1, st, 1'b1, src, tgt, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, o_pc, 32'h0);
    check({tag, "_instr"}, o_instr, 32'h0);
    check({tag, "_imm16"}, {16'h0, o_imm16}, 32'h0);
    check({tag, "_pp4"}, o_pc_plus4, 32'h0);
    check({tag, "_valid"}, {31'h0, o_valid}, 32'h0);
    check({tag, "_halt"}, {31'h0, o_halt}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w, t, popped;
    logic [7:0]  a;
    logic        en, st, fl, we;
    logic [1:0]  src;

    i_enable = 0; i_stall = 0; i_flush = 0; i_pc_src = 0;
    i_branch_target = 0; i_jump_target = 0; i_jr_target = 0;
    i_imem_we = 0; i_imem_waddr = 0; i_imem_wdata = 0;
    rst_n = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    #11 rst_n = 1;
    @(posedge clk); #2;
    chk_en = 1'b1;

    // Program: ADDI, ADDI, HALT, then identifiable filler words.
    for (int i = 0; i < 256; i++) begin
      w = (i == 0) ? 32'h2001_0005 : (i == 1) ? 32'h2002_0007 :
          (i == 2) ? 32'hFC00_0000 : (32'h2000_0000 | 32'(i));
      load_word(8'(i), w);
    end

    exp_q.push_back(32'h2001_0005);
    exp_q.push_back(32'h2002_0007);
    exp_q.push_back(32'hFC00_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      popped = exp_q.pop_front();
      check("seq_instr", o_instr, popped);
      check("seq_pp4", o_pc_plus4, 32'(4 * (i + 1)));
      if (i == 0) check("seq_imm0", {16'h0, o_imm16}, 32'h0005);
      if (i == 1) check("seq_imm1", {16'h0, o_imm16}, 32'h0007);
    end
    check("pre_halt", {31'h0, o_halt}, 32'h0);
    step();
    check("halt_set", {31'h0, o_halt}, 32'h1);
    check("halt_pc", o_pc, 32'd12);
    step();
    check("halt_frozen_pc", o_pc, 32'd12);

    // Branch redirect with flush, out of the halted state.
    flush_to(2'b01, 32'h40, 1'b0);
    check("br_nop", o_instr, 32'h0);
    check("br_valid", {31'h0, o_valid}, 32'h0);
    check("br_pc", o_pc, 32'h40);
    check("br_unhalt", {31'h0, o_halt}, 32'h0);
    step();
    check("br_word16", o_instr, 32'h2000_0010);
    check("br_pp4", o_pc_plus4, 32'h44);
    step();
    check("pre_stall", o_instr, 32'h2000_0011);

    // Two stall cycles, then resume without skipping.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 8'h0, 32'h0);
      check("stall_instr", o_instr, 32'h2000_0011);
      check("stall_pp4", o_pc_plus4, 32'h48);
      check("stall_pc", o_pc, 32'h48);
    end
    step();
    check("resume_instr", o_instr, 32'h2000_0012);

    // Stall and flush together: flush wins.
    flush_to(2'b10, 32'h100, 1'b1);
    check("sf_nop", o_instr, 32'h0);
    check("sf_pc", o_pc, 32'h100);
    step();
    check("sf_next", o_instr, 32'h2000_0040);

    // Re-halt at 0x8, then release with a JR flush to 0x8.
    flush_to(2'b11, 32'h8, 1'b0);
    step();
    step();
    check("rehalt", {31'h0, o_halt}, 32'h1);
    flush_to(2'b11, 32'h8, 1'b0);
    check("jr_unhalt", {31'h0, o_halt}, 32'h0);
    check("jr_pc", o_pc, 32'h8);
    step();
    check("jr_fetch", o_instr, 32'hFC00_0000);
    check("jr_pc2", o_pc, 32'd12);

    // PC wrap at the top of the address space.
    flush_to(2'b11, 32'hFFFF_FFFC, 1'b0);
    check("wrap_pc", o_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_instr", o_instr, 32'h2000_00FF);
    check("wrap_pp4", o_pc_plus4, 32'h0);
    check("wrap_next_pc", o_pc, 32'h0);
    step();
    check("wrap_word0", o_instr, 32'h2001_0005);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a   = 8'($urandom_range(0, 255));
      t   = ($urandom_range(0, 3) == 0) ? $urandom : {22'h0, a, 2'b00};
      we  = ($urandom_range(0, 1) == 0);
      w   = ($urandom_range(0, 15) == 0) ? {6'h3F, 26'($urandom)} : $urandom;
      drive(en, st, fl, src, t, we, 8'($urandom_range(0, 255)), w);
    end

    // Asynchronous reset mid-cycle, then confirm memory survived reset.
    step();
    step();
    #1 rst_n = 0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    #2 rst_n = 1;
    for (int i = 0; i < 4; i++) step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
